mem_arb_ctrl: RTL and testbench
===============================

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 The block SHALL have one parameter: MEM_LAT, default 2, memory read latency in cycles, legal range 1..15.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  fetch requester (port 0) read request; held high until if_ack.
REQ-006 if_addr  in  16  fetch address.
REQ-007 if_ack  out  1  one-cycle pulse: fetch transaction complete, rdata valid.
REQ-008 d_req  in  1  data requester (port 1) request; held high until d_ack.
REQ-009 d_we  in  1  data request is a write when 1.
REQ-010 d_addr  in  16  data address.
REQ-011 d_wdata  in  16  data write value.
REQ-012 d_ack  out  1  one-cycle pulse: data transaction complete.
REQ-013 rdata  out  16  MDR contents; valid in the ack cycle, held until the next capture.
REQ-014 mem_addr  out  16  MAR to memory.
REQ-015 mem_en  out  1  memory access strobe, one cycle per transaction.
REQ-016 mem_we  out  1  LDMEM: write strobe, only with mem_en.
REQ-017 mem_wdata  out  16  MDR write value to memory.
REQ-018 mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_en.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 gnt  out  1  index of current or last grantee (0 fetch, 1 data).

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS, WAIT, DONE.
REQ-022 IDLE: on a clock edge where any request is high, the block SHALL grant one port, latch address/we/wdata into MAR/MDR and enter ACCESS.
REQ-023 Arbitration SHALL be two-way round robin: with both requests high, the port not granted last SHALL win; with one request high, that port SHALL win.
REQ-024 ACCESS SHALL last exactly 1 cycle with mem_en=1, mem_addr=MAR, mem_we=granted we (always 0 for fetch), mem_wdata=MDR.
REQ-025 WAIT SHALL last exactly MEM_LAT cycles via a 4-bit down-counter; on the edge ending the last WAIT cycle, a read SHALL load mem_rdata into MDR and a write SHALL leave MDR holding the written value.
REQ-026 DONE SHALL last 1 cycle and assert the grantee's ack only; rdata=MDR.
REQ-027 From DONE the block SHALL go directly to ACCESS if the other port requests (the grantee's still-high req SHALL be ignored that cycle), else to IDLE.
REQ-028 Latency: a request sampled at edge k SHALL see ack high in cycle k+MEM_LAT+2 when uncontended.
REQ-029 Deassertion of a req after grant SHALL NOT abort the transaction; ack still pulses.
REQ-030 Changes to addr/we/wdata after grant SHALL NOT affect the transaction.
REQ-031 mem_en, mem_we, if_ack, d_ack SHALL never be high outside ACCESS/DONE respectively; if_ack and d_ack SHALL never be high together.

Reset
REQ-032 While rst_n=0: state IDLE, counter 0, MAR 0, MDR 0, rdata 0, all strobes/acks 0, busy 0, gnt 1 (so fetch wins the first contended arbitration).
REQ-033 Reset asserted mid-transaction SHALL immediately drop mem_en/mem_we and discard the transaction without ack.

Structure
REQ-034 A shared package mem_ctrl_pkg SHALL hold the state encoding, PORT_FETCH=0, PORT_DATA=1, and the MEM_LAT range limits.
REQ-035 Arbitration SHALL be a sub-module rr_arb2 (two requests, enable, last-grant register, grant index out).

Verification
REQ-036 MEM_LAT=2, fetch read addr 0x3000, memory returns 0x1234 -> mem_en one cycle after request, if_ack 4 cycles after request, rdata=0x1234.
REQ-037 Data write addr 0x4000 data 0xBEEF -> mem_we=1 only in ACCESS with mem_wdata=0xBEEF, d_ack at k+4, rdata=0xBEEF.
REQ-038 Both req high from reset -> fetch first, data DONE->ACCESS back-to-back, acks 4 cycles apart, no idle cycle.
REQ-039 Both requests held continuously -> grants strictly alternate 0,1,0,1 over 8 transactions.
REQ-040 rst_n low during WAIT -> no ack, outputs zero immediately, next request completes normally.
REQ-041 MEM_LAT=1 and 15 -> ack at k+3 and k+17 respectively.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types and constants for the two-port memory
//                arbiter/controller: FSM state encoding, port indices and
//                the legal range of the memory read latency.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    // Controller FSM states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Requester indices used by the arbiter and the grant output
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // Legal memory read latency, in cycles
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    // Width of the WAIT down-counter (holds MEM_LAT_MAX - 1)
    localparam int CNT_W = 4;

    // Index of the requester that is not p
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. With both requests high the
//                port not granted last wins; a lone requester always wins.
//                The last-grant register only moves when a grant is issued.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_idx,
    output logic       gnt_valid,
    output logic       last_gnt
);

    logic r_last;
    logic w_win;

    // Pick the winner from the current requests and the previous grantee
    always_comb begin
        case (req)
            2'b11:   w_win = other_port(r_last);
            2'b10:   w_win = PORT_DATA;
            default: w_win = PORT_FETCH;
        endcase
    end

    // Remember the grantee; reset to data so fetch wins the first contest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_DATA;
        end else if (en && (req != 2'b00)) begin
            r_last <= w_win;
        end
    end

    assign gnt_idx   = w_win;
    assign gnt_valid = en && (req != 2'b00);
    assign last_gnt  = r_last;

endmodule
`default_nettype wire

// File: rtl/mem_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_ctrl
//  Description : Two-port (fetch / data) memory controller. A round-robin
//                arbiter picks a requester, its address and write data are
//                captured into MAR/MDR, memory is strobed for one cycle,
//                the controller waits MEM_LAT cycles and then pulses the
//                grantee's ack with the transaction result on rdata.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] rdata,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        gnt
);

    // Out-of-range latencies are pulled into the supported window
    localparam int c_lat_eff = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                               (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(c_lat_eff - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_mar;
    logic [15:0]      r_mdr;
    logic [15:0]      r_rdata;
    logic             r_we;
    logic             r_mem_en;
    logic             r_mem_we;
    logic             r_if_ack;
    logic             r_d_ack;

    logic [1:0]       w_arb_req;
    logic             w_arb_en;
    logic             w_win;
    logic             w_grant;
    logic             w_last;
    logic [15:0]      w_sel_addr;
    logic [15:0]      w_sel_wdata;
    logic             w_sel_we;

    // Arbitrate in IDLE, and in DONE for the other port only (back-to-back)
    always_comb begin
        w_arb_en  = 1'b0;
        w_arb_req = {d_req, if_req};
        case (r_state)
            IDLE: begin
                w_arb_en = 1'b1;
            end
            DONE: begin
                w_arb_en          = 1'b1;
                w_arb_req[w_last] = 1'b0;
            end
            default: begin
                w_arb_en = 1'b0;
            end
        endcase
    end

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (w_arb_req),
        .en        (w_arb_en),
        .gnt_idx   (w_win),
        .gnt_valid (w_grant),
        .last_gnt  (w_last)
    );

    // Route the winning port's address / direction / write data to MAR/MDR
    always_comb begin
        if (w_win == PORT_DATA) begin
            w_sel_addr  = d_addr;
            w_sel_we    = d_we;
            w_sel_wdata = d_wdata;
        end else begin
            w_sel_addr  = if_addr;
            w_sel_we    = 1'b0;
            w_sel_wdata = 16'h0000;
        end
    end

    // Controller FSM with registered strobes and acks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mar    <= 16'h0000;
            r_mdr    <= 16'h0000;
            r_rdata  <= 16'h0000;
            r_we     <= 1'b0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_grant) begin
                        r_mar    <= w_sel_addr;
                        r_we     <= w_sel_we;
                        r_mdr    <= w_sel_wdata;
                        r_mem_en <= 1'b1;
                        r_mem_we <= w_sel_we;
                        r_state  <= ACCESS;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                ACCESS: begin
                    r_cnt   <= c_wait_load;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        // A write keeps its own value in MDR as the result
                        if (!r_we) begin
                            r_mdr <= mem_rdata;
                        end
                        r_rdata <= r_we ? r_mdr : mem_rdata;
                        if (w_last == PORT_DATA) begin
                            r_d_ack  <= 1'b1;
                        end else begin
                            r_if_ack <= 1'b1;
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mar;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mdr;
    assign busy      = (r_state != IDLE);
    assign gnt       = w_last;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arb_ctrl
//  Description : Self-checking bench for mem_arb_ctrl. A transaction-level
//                model predicts grant order, access/ack cycles and result
//                data; a memory responder returns data MEM_LAT cycles after
//                each read strobe. Extra instances cover latencies 1 and 15.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arb_ctrl;

    localparam int L = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        if_ack, d_ack, mem_en, mem_we, busy, gnt;
    logic [15:0] rdata, mem_addr, mem_wdata;

    mem_arb_ctrl #(.MEM_LAT(L)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .gnt(gnt)
    );

    // latency-extreme instances: fetch only, memory data held constant
    logic        l1_req = 1'b0, l15_req = 1'b0;
    logic        l1_ack, l1_dack, l1_en, l1_we, l1_busy, l1_gnt;
    logic        l15_ack, l15_dack, l15_en, l15_we, l15_busy, l15_gnt;
    logic [15:0] l1_rdata, l1_maddr, l1_mwdata, l15_rdata, l15_maddr, l15_mwdata;

    mem_arb_ctrl #(.MEM_LAT(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(l1_req), .if_addr(16'h0100), .if_ack(l1_ack),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000), .d_ack(l1_dack),
        .rdata(l1_rdata), .mem_addr(l1_maddr), .mem_en(l1_en), .mem_we(l1_we),
        .mem_wdata(l1_mwdata), .mem_rdata(16'h0F0F), .busy(l1_busy), .gnt(l1_gnt)
    );

    mem_arb_ctrl #(.MEM_LAT(15)) u_l15 (
        .clk(clk), .rst_n(rst_n),
        .if_req(l15_req), .if_addr(16'h0200), .if_ack(l15_ack),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000), .d_ack(l15_dack),
        .rdata(l15_rdata), .mem_addr(l15_maddr), .mem_en(l15_en), .mem_we(l15_we),
        .mem_wdata(l15_mwdata), .mem_rdata(16'hF0F0), .busy(l15_busy), .gnt(l15_gnt)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- observation records (cycle n = period ending at edge n)
    typedef struct { int cyc; bit port; logic [15:0] data; } ack_t;
    typedef struct { int cyc; logic [15:0] addr; logic we; logic [15:0] wdata; } acc_t;
    ack_t acks[$];
    acc_t accs[$];
    int both_ack_cnt = 0, we_wo_en_cnt = 0, busy_bad_cnt = 0;

    always @(negedge clk) begin
        ack_t a;
        acc_t m;
        if (if_ack || d_ack) begin
            a.cyc = cyc + 1; a.port = d_ack; a.data = rdata;
            acks.push_back(a);
        end
        if (mem_en) begin
            m.cyc = cyc + 1; m.addr = mem_addr; m.we = mem_we; m.wdata = mem_wdata;
            accs.push_back(m);
        end
        if (if_ack && d_ack) both_ack_cnt++;
        if (mem_we && !mem_en) we_wo_en_cnt++;
        if ((mem_en || if_ack || d_ack) && !busy) busy_bad_cnt++;
    end

    // ---------------- memory: bench-side storage and reference model
    logic [15:0] mem     [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    bit          pend = 0;
    int          pcnt = 0;
    logic [15:0] paddr = '0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pend = 0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else begin pend = 1; pcnt = L; paddr = mem_addr; end
        end else if (pend) begin
            pcnt--;
        end
        if (pend && pcnt == 0) begin
            mem_rdata = mem.exists(paddr) ? mem[paddr] : init_word(paddr);
            pend = 0;
        end else begin
            mem_rdata = 16'($urandom);
        end
    end

    bit model_last = 1'b1;   // last grantee per the arbitration rule

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Raise the selected requests, hold each until its ack, then drop it
    task automatic issue(input bit use_f, input logic [15:0] fa,
                         input bit use_d, input bit we, input logic [15:0] da,
                         input logic [15:0] dw, output int k, output bit timed_out);
        int budget;
        acks.delete(); accs.delete();
        if_addr = fa; d_addr = da; d_we = we; d_wdata = dw;
        if_req = use_f; d_req = use_d;
        k = cyc + 1;
        budget = 0;
        while ((if_req || d_req) && budget < 80) begin
            tick();
            budget++;
            if (if_ack) if_req = 1'b0;
            if (d_ack)  d_req  = 1'b0;
        end
        timed_out = if_req || d_req;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vectors++; if ({if_ack, d_ack, mem_en, mem_we, busy} !== 5'b0) begin miscompares++;
            $display("FAIL reset_strobes: got %b want 00000", {if_ack, d_ack, mem_en, mem_we, busy}); end
        vectors++; if (gnt !== 1'b1) begin miscompares++; $display("FAIL reset_gnt: got %b want 1", gnt); end
        vectors++; if ({rdata, mem_addr, mem_wdata} !== 48'h0) begin miscompares++;
            $display("FAIL reset_data: got %h want 0", {rdata, mem_addr, mem_wdata}); end
        rst_n = 1'b1;
        tick();
        model_last = 1'b1;
    endtask

    task automatic test_fetch_read();
        int k; bit to;
        mem[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;
        issue(1, 16'h3000, 0, 0, 16'h0, 16'h0, k, to);
        vectors++; if (to || accs.size() != 1 || acks.size() != 1) begin miscompares++;
            $display("FAIL fetch_count: got acc=%0d ack=%0d timeout=%0d want 1 1 0", accs.size(), acks.size(), to); end
        else begin
            vectors++; if (accs[0].cyc !== k + 1 || accs[0].addr !== 16'h3000 || accs[0].we !== 1'b0) begin miscompares++;
                $display("FAIL fetch_access: got cyc=%0d addr=%h we=%b want %0d 3000 0", accs[0].cyc, accs[0].addr, accs[0].we, k + 1); end
            vectors++; if (acks[0].cyc !== k + L + 2 || acks[0].port !== 1'b0 || acks[0].data !== 16'h1234) begin miscompares++;
                $display("FAIL fetch_ack: got cyc=%0d port=%0d data=%h want %0d 0 1234", acks[0].cyc, acks[0].port, acks[0].data, k + L + 2); end
        end
        vectors++; if (rdata !== 16'h1234 || gnt !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL fetch_after: got rdata=%h gnt=%b busy=%b want 1234 0 0", rdata, gnt, busy); end
        model_last = 1'b0;
    endtask

    task automatic test_data_write();
        int k; bit to;
        issue(0, 16'h0, 1, 1, 16'h4000, 16'hBEEF, k, to);
        ref_mem[16'h4000] = 16'hBEEF;
        vectors++; if (to || accs.size() != 1 || acks.size() != 1) begin miscompares++;
            $display("FAIL write_count: got acc=%0d ack=%0d timeout=%0d want 1 1 0", accs.size(), acks.size(), to); end
        else begin
            vectors++; if (accs[0].cyc !== k + 1 || accs[0].addr !== 16'h4000 || accs[0].we !== 1'b1 || accs[0].wdata !== 16'hBEEF) begin
                miscompares++;
                $display("FAIL write_access: got cyc=%0d addr=%h we=%b wd=%h want %0d 4000 1 beef", accs[0].cyc, accs[0].addr, accs[0].we, accs[0].wdata, k + 1); end
            vectors++; if (acks[0].cyc !== k + 4 || acks[0].port !== 1'b1 || acks[0].data !== 16'hBEEF) begin miscompares++;
                $display("FAIL write_ack: got cyc=%0d port=%0d data=%h want %0d 1 beef", acks[0].cyc, acks[0].port, acks[0].data, k + 4); end
        end
        model_last = 1'b1;
    endtask

    task automatic test_both_from_reset();
        int k; bit to;
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        model_last = 1'b1;
        issue(1, 16'h3000, 1, 0, 16'h4000, 16'h0, k, to);
        vectors++; if (to || acks.size() != 2 || accs.size() != 2) begin miscompares++;
            $display("FAIL both_count: got ack=%0d acc=%0d timeout=%0d want 2 2 0", acks.size(), accs.size(), to); end
        else begin
            vectors++; if (acks[0].port !== 1'b0 || acks[0].cyc !== k + L + 2 || acks[0].data !== 16'h1234) begin miscompares++;
                $display("FAIL both_first: got port=%0d cyc=%0d data=%h want 0 %0d 1234", acks[0].port, acks[0].cyc, acks[0].data, k + L + 2); end
            vectors++; if (acks[1].port !== 1'b1 || acks[1].cyc !== acks[0].cyc + 4 || acks[1].data !== 16'hBEEF) begin miscompares++;
                $display("FAIL both_second: got port=%0d cyc=%0d data=%h want 1 %0d beef", acks[1].port, acks[1].cyc, acks[1].data, acks[0].cyc + 4); end
            vectors++; if (accs[1].cyc !== acks[0].cyc + 1) begin miscompares++;
                $display("FAIL both_no_idle: got access cyc=%0d want %0d", accs[1].cyc, acks[0].cyc + 1); end
        end
        model_last = 1'b1;
    endtask

    task automatic test_alternate();
        int n, budget; bit first;
        acks.delete(); accs.delete();
        if_addr = 16'h3000; d_addr = 16'h4000; d_we = 1'b0;
        first = ~model_last;
        if_req = 1'b1; d_req = 1'b1;
        n = 0; budget = 0;
        while (n < 8 && budget < 200) begin
            tick(); budget++;
            if (if_ack || d_ack) n++;
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk); tick();
        vectors++; if (acks.size() != 8 || accs.size() != 8) begin miscompares++;
            $display("FAIL alt_count: got ack=%0d acc=%0d want 8 8", acks.size(), accs.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                bit p;
                p = first ^ i[0];
                vectors++;
                if (acks[i].port !== p || acks[i].data !== ref_read(p ? 16'h4000 : 16'h3000) ||
                    (i > 0 && acks[i].cyc !== acks[i-1].cyc + L + 2)) begin
                    miscompares++;
                    $display("FAIL alt_%0d: got port=%0d data=%h cyc=%0d want port=%0d data=%h", i, acks[i].port,
                             acks[i].data, acks[i].cyc, p, ref_read(p ? 16'h4000 : 16'h3000));
                end
            end
        end
        model_last = ~first;
    endtask

    task automatic test_hold_after_grant();
        int k, budget;
        acks.delete(); accs.delete();
        d_addr = 16'h4444; d_we = 1'b1; d_wdata = 16'h1357; d_req = 1'b1;
        k = cyc + 1;
        tick();                              // ACCESS: grant taken, scramble inputs
        d_req = 1'b0; d_addr = 16'h9999; d_we = 1'b0; d_wdata = 16'hFFFF;
        budget = 0;
        while (acks.size() == 0 && budget < 20) begin tick(); budget++; end
        repeat (3) tick();
        ref_mem[16'h4444] = 16'h1357;
        vectors++; if (acks.size() != 1 || accs.size() != 1) begin miscompares++;
            $display("FAIL hold_count: got ack=%0d acc=%0d want 1 1", acks.size(), accs.size()); end
        else begin
            vectors++; if (acks[0].cyc !== k + L + 2 || acks[0].port !== 1'b1 || acks[0].data !== 16'h1357) begin miscompares++;
                $display("FAIL hold_ack: got cyc=%0d port=%0d data=%h want %0d 1 1357", acks[0].cyc, acks[0].port, acks[0].data, k + L + 2); end
            vectors++; if (accs[0].addr !== 16'h4444 || accs[0].we !== 1'b1 || accs[0].wdata !== 16'h1357) begin miscompares++;
                $display("FAIL hold_access: got addr=%h we=%b wd=%h want 4444 1 1357", accs[0].addr, accs[0].we, accs[0].wdata); end
        end
        model_last = 1'b1;
    endtask

    task automatic test_reset_mid();
        int k; bit to;
        acks.delete();
        if_addr = 16'h2222; if_req = 1'b1;
        tick(); tick();                      // now in the first WAIT cycle
        vectors++; if (busy !== 1'b1 || mem_en !== 1'b0) begin miscompares++;
            $display("FAIL rstmid_pre: got busy=%b mem_en=%b want 1 0", busy, mem_en); end
        #3 rst_n = 1'b0;
        #1;
        vectors++; if ({mem_en, mem_we, if_ack, d_ack, busy} !== 5'b0 || gnt !== 1'b1 || mem_addr !== 16'h0 || rdata !== 16'h0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got strobes=%b gnt=%b addr=%h rdata=%h want 00000 1 0 0",
                     {mem_en, mem_we, if_ack, d_ack, busy}, gnt, mem_addr, rdata); end
        if_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        vectors++; if (acks.size() != 0) begin miscompares++;
            $display("FAIL rstmid_noack: got %0d acks want 0", acks.size()); end
        model_last = 1'b1;
        issue(1, 16'h2468, 0, 0, 16'h0, 16'h0, k, to);
        vectors++; if (to || acks.size() != 1 || acks[0].cyc !== k + L + 2 || acks[0].data !== ref_read(16'h2468)) begin
            miscompares++;
            $display("FAIL rstmid_recover: got acks=%0d timeout=%0d want one ack at %0d data %h", acks.size(), to, k + L + 2, ref_read(16'h2468)); end
        model_last = 1'b0;
    endtask

    task automatic test_lat_extremes();
        int k, a1, a15, n1, n15;
        a1 = -1; a15 = -1; n1 = 0; n15 = 0;
        l1_req = 1'b1; l15_req = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (l1_ack)  begin n1++;  if (a1 < 0)  a1  = cyc + 1; l1_req  = 1'b0; end
            if (l15_ack) begin n15++; if (a15 < 0) a15 = cyc + 1; l15_req = 1'b0; end
        end
        l1_req = 1'b0; l15_req = 1'b0;
        vectors++; if (a1 != k + 3 || n1 != 1 || l1_rdata !== 16'h0F0F) begin miscompares++;
            $display("FAIL lat1: got ack cyc=%0d pulses=%0d rdata=%h want %0d 1 0f0f", a1, n1, l1_rdata, k + 3); end
        vectors++; if (a15 != k + 17 || n15 != 1 || l15_rdata !== 16'hF0F0) begin miscompares++;
            $display("FAIL lat15: got ack cyc=%0d pulses=%0d rdata=%h want %0d 1 f0f0", a15, n15, l15_rdata, k + 17); end
    endtask

    task automatic test_random();
        int k, n, mode, gap;
        bit to, use_f, use_d, we, first, p;
        logic [15:0] fa, da, dw, e_addr, e_data;
        int e_acc;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(1, 3);
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            fa = 16'h5000 | 16'($urandom_range(0, 15));
            da = 16'h5000 | 16'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            dw = 16'($urandom);
            use_f = (mode != 2); use_d = (mode != 1);
            issue(use_f, fa, use_d, we, da, dw, k, to);
            n = int'(use_f) + int'(use_d);
            first = (n == 2) ? ~model_last : use_d;
            vectors++; if (to || acks.size() != n || accs.size() != n) begin miscompares++;
                $display("FAIL rnd%0d_count: got ack=%0d acc=%0d timeout=%0d want %0d", it, acks.size(), accs.size(), to, n); end
            else begin
                for (int i = 0; i < n; i++) begin
                    p = (i == 0) ? first : ~first;
                    e_acc = (i == 0) ? k + 1 : k + L + 3;
                    e_addr = p ? da : fa;
                    if (p && we) begin e_data = dw; ref_mem[da] = dw; end
                    else e_data = ref_read(e_addr);
                    vectors++;
                    if (accs[i].cyc !== e_acc || accs[i].addr !== e_addr || accs[i].we !== (p & we) ||
                        ((p & we) && accs[i].wdata !== dw)) begin
                        miscompares++;
                        $display("FAIL rnd%0d_access%0d: got cyc=%0d addr=%h we=%b wd=%h want %0d %h %b %h", it, i,
                                 accs[i].cyc, accs[i].addr, accs[i].we, accs[i].wdata, e_acc, e_addr, p & we, dw);
                    end
                    vectors++;
                    if (acks[i].cyc !== e_acc + L + 1 || acks[i].port !== p || acks[i].data !== e_data) begin
                        miscompares++;
                        $display("FAIL rnd%0d_ack%0d: got cyc=%0d port=%0d data=%h want %0d %0d %h", it, i,
                                 acks[i].cyc, acks[i].port, acks[i].data, e_acc + L + 1, p, e_data);
                    end
                end
            end
            model_last = (n == 2) ? ~first : first;
        end
    endtask

    task automatic test_invariants();
        vectors++; if (both_ack_cnt != 0) begin miscompares++;
            $display("FAIL inv_both_acks: got %0d cycles want 0", both_ack_cnt); end
        vectors++; if (we_wo_en_cnt != 0) begin miscompares++;
            $display("FAIL inv_we_without_en: got %0d cycles want 0", we_wo_en_cnt); end
        vectors++; if (busy_bad_cnt != 0) begin miscompares++;
            $display("FAIL inv_busy: got %0d cycles want 0", busy_bad_cnt); end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_data_write();
        test_both_from_reset();
        test_alternate();
        test_hold_after_grant();
        test_lat_extremes();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
